// File: rtl/rob_recovery_ctrl.sv
// Reorder-buffer recovery sequencer: on a head mispredict, runs FLUSH -> DRAIN -> REDIRECT.
// Optional performance counters are enabled with `define ROB_RECOVERY_PERF_EN.
module rob_recovery_ctrl #(
    parameter int PC_WIDTH     = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                head_valid,
    input  logic                head_br_mispred,
    input  logic                head_ld_mispred,
    input  logic [PC_WIDTH-1:0] head_pc,
    input  logic [PC_WIDTH-1:0] head_br_target,
    output logic                flush,
    output logic                dispatch_stall,
    output logic                redirect_valid,
    input  logic                redirect_ready,
    output logic [PC_WIDTH-1:0] redirect_pc,
`ifdef ROB_RECOVERY_PERF_EN
    output logic [31:0]         perf_recover_count,
    output logic [31:0]         perf_stall_cycles,
`endif
    output logic                recover_cause
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        DRAIN    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    logic       trigger;

    assign trigger = head_valid & (head_br_mispred | head_ld_mispred);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            drain_cnt     <= 4'd0;
            redirect_pc   <= '0;
            recover_cause <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state         <= FLUSH;
                        // A load is refetched from its own PC; ld wins if both flags set.
                        recover_cause <= head_ld_mispred;
                        redirect_pc   <= head_ld_mispred ? head_pc : head_br_target;
                    end
                end
                FLUSH: begin
                    drain_cnt <= DRAIN_LOAD;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state <= REDIRECT;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only the state register, so no input reaches them combinationally.
    assign flush          = (state == FLUSH);
    assign dispatch_stall = (state != IDLE);
    assign redirect_valid = (state == REDIRECT);

`ifdef ROB_RECOVERY_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_recover_count <= 32'd0;
            perf_stall_cycles  <= 32'd0;
        end else begin
            if (flush && (perf_recover_count != 32'hFFFF_FFFF)) begin
                perf_recover_count <= perf_recover_count + 32'd1;
            end
            if (dispatch_stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
